spy_recorder: RTL
=================

Name: spy_recorder

Overview:
Capture-side controller for the spy memory; it writes the same memory that the playback controller reads.
- Records the data stream into spy memory as a circular buffer.
- Freezes after a programmable number of post-trigger words.
- Streams the frozen contents out, oldest word first, over a valid/ready readout port.
- Its spy_write_addr output is the stop/loop pointer the playback controller consumes.

Parameters:
DATAWIDTH, 64, data width excluding the metadata bit; the stored word is DATAWIDTH+1 bits.
MEMWIDTH, 6, spy memory address width; depth is 2**MEMWIDTH.
FREEZE_DELAY, 8, words recorded after freeze_req before freezing; range 0 .. 2**MEMWIDTH-1.

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high
data_in  in  DATAWIDTH+1  stream word, metadata bit at [DATAWIDTH]
data_valid  in  1  data_in is valid this cycle
freeze_req  in  1  single-cycle freeze trigger
unfreeze  in  1  single-cycle resume-recording pulse
playback  in  2  playback mode: NO_PLAYBACK=00, PLAYBACK_ONCE=01, PLAYBACK_LOOP=10, PLAYBACK_WRITE=11
spy_write_enable  out  1  memory write strobe
spy_write_addr  out  MEMWIDTH  address of the most recently written word
spy_write_data  out  DATAWIDTH+1  memory write data
spy_read_enable  out  1  memory read strobe; read data returns 1 cycle later
spy_read_addr  out  MEMWIDTH  memory read address
spy_read_data  in  DATAWIDTH+1  memory read data
readout_start  in  1  single-cycle pulse: begin block readout
readout_data  out  DATAWIDTH+1  readout word
readout_valid  out  1  readout_data is valid
readout_ready  in  1  consumer accepts the word
readout_last  out  1  qualifies the final word of a readout
frozen  out  1  high in the FROZEN and READOUT states
wrapped  out  1  memory has been filled at least once since reset/unfreeze

Behaviour:
- Reset values:
  - state RECORD; spy_write_addr = 2**MEMWIDTH-1, so the first write lands at address 0.
  - Word count 0; wrapped 0; frozen 0.
  - All strobes and valids 0; data outputs 0.
  - The 2-entry readout buffer is emptied and any in-flight read is discarded.
- Recording (states RECORD, POST_TRIGGER), only when playback==NO_PLAYBACK:
  - On data_valid, the next cycle gives spy_write_enable=1, spy_write_data=data_in, spy_write_addr=previous+1 (mod 2**MEMWIDTH).
  - Write latency is exactly 1 cycle.
  - Word count saturates at 2**MEMWIDTH; wrapped = (count == 2**MEMWIDTH).
- Playback != NO_PLAYBACK:
  - No writes; spy_write_addr, count, state and the post-trigger counter all hold.
  - readout_start is ignored.
- RECORD -> POST_TRIGGER on freeze_req:
  - A word valid in the freeze_req cycle is recorded as pre-trigger.
  - The post-trigger counter loads FREEZE_DELAY.
  - With FREEZE_DELAY=0, go directly to FROZEN.
- POST_TRIGGER:
  - Each recorded word decrements the counter.
  - The cycle recording the last post-trigger word transitions to FROZEN.
  - freeze_req is ignored.
- FROZEN:
  - No writes.
  - readout_start with playback==NO_PLAYBACK and count>0 -> READOUT; otherwise readout_start is ignored.
  - unfreeze -> RECORD, resetting spy_write_addr to all-ones and count/wrapped to 0 (memory contents untouched).
  - freeze_req is ignored.
- READOUT:
  - Start address is spy_write_addr+1 if wrapped, else 0; word total is count.
  - Reads use sequential addresses with wrap-around.
  - A read is issued only when buffer occupancy plus in-flight reads < 2. This sustains 1 word/cycle while readout_ready is held high.
  - Transfer occurs when readout_valid && readout_ready. readout_data/readout_valid/readout_last stay stable until the transfer.
  - The last word is transferred -> FROZEN; readout is repeatable.
  - unfreeze and freeze_req are ignored.
  - playback leaving NO_PLAYBACK aborts: readout_valid drops next cycle, the buffer is flushed, state -> FROZEN.
- spy_read_enable is asserted only in READOUT. spy_read_addr holds its value otherwise.
- Simultaneous events:
  - reset overrides everything.
  - In RECORD with FREEZE_DELAY=0, data_valid+freeze_req in the same cycle writes the word, then the block freezes.

Test Plan:
(MEMWIDTH=3, FREEZE_DELAY=2, Dn = n)
1. Reset, then 5 valid words D0..D4 -> writes to addresses 0..4, each 1 cycle after input; spy_write_addr=4; wrapped=0; frozen=0.
2. 11 words D0..D10, freeze_req with D11, then D12, D13 -> frozen after D13 at addr 5; later data_valid produces no writes; wrapped=1.
3. From scenario 2, readout_start with ready held high -> 8 consecutive-cycle words D6..D13; readout_last only on D13; frozen remains 1.
4. Readout with readout_ready pattern 1,0,0,1,0,1,1 -> all words in order, none duplicated or lost; data stable while ready=0.
5. playback=PLAYBACK_ONCE while recording D0..D2 -> no write strobes, spy_write_addr holds; switching playback to 01 mid-readout -> readout_valid low next cycle, state FROZEN; a new readout_start with playback=00 restarts from the oldest word.
6. reset asserted mid-readout -> next cycle readout_valid=0, frozen=0, spy_write_addr=7; next data_valid writes address 0.

Source files
------------

// File: rtl/spy_recorder.sv
// Capture-side spy memory controller: circular recording, delayed freeze after a
// trigger, and oldest-first block readout of the frozen contents.
module spy_recorder #(
  parameter int DATAWIDTH    = 64,
  parameter int MEMWIDTH     = 6,
  parameter int FREEZE_DELAY = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATAWIDTH:0]    data_in,
  input  logic                  data_valid,
  input  logic                  freeze_req,
  input  logic                  unfreeze,
  input  logic [1:0]            playback,
  output logic                  spy_write_enable,
  output logic [MEMWIDTH-1:0]   spy_write_addr,
  output logic [DATAWIDTH:0]    spy_write_data,
  output logic                  spy_read_enable,
  output logic [MEMWIDTH-1:0]   spy_read_addr,
  input  logic [DATAWIDTH:0]    spy_read_data,
  input  logic                  readout_start,
  output logic [DATAWIDTH:0]    readout_data,
  output logic                  readout_valid,
  input  logic                  readout_ready,
  output logic                  readout_last,
  output logic                  frozen,
  output logic                  wrapped,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_RECORD  = 2'd0,
    ST_POST    = 2'd1,
    ST_FROZEN  = 2'd2,
    ST_READOUT = 2'd3
  } state_t;

  localparam logic [MEMWIDTH:0]   DEPTH_C = {1'b1, {MEMWIDTH{1'b0}}};
  localparam logic [MEMWIDTH-1:0] FD_W    = MEMWIDTH'(FREEZE_DELAY);

  state_t                state_q, state_d;
  logic                  wen_q, wen_d;
  logic [MEMWIDTH-1:0]   waddr_q, waddr_d;
  logic [DATAWIDTH:0]    wdata_q, wdata_d;
  logic [MEMWIDTH:0]     count_q, count_d;
  logic [MEMWIDTH-1:0]   post_q, post_d;
  logic [MEMWIDTH-1:0]   raddr_q, raddr_d;
  logic [MEMWIDTH:0]     issue_left_q, issue_left_d;
  logic [MEMWIDTH:0]     xfer_left_q, xfer_left_d;
  logic [DATAWIDTH:0]    buf0_q, buf0_d, buf1_q, buf1_d;
  logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;

  logic                  rec_ok, recording, pop, push, abort, issue, last_xfer, wrapped_w;
  logic [2:0]            occ_plus;

  // Readout handshake: a word moves when readout_valid && readout_ready in the same
  // cycle; while valid is high and ready is low, data/valid/last do not change.
  always_comb begin
    rec_ok    = (playback == 2'b00);
    recording = rec_ok && data_valid && (state_q == ST_RECORD || state_q == ST_POST);
    wrapped_w = (count_q == DEPTH_C);
    abort     = (state_q == ST_READOUT) && !rec_ok;
    pop       = (state_q == ST_READOUT) && (occ_q != 2'd0) && readout_ready;
    push      = (state_q == ST_READOUT) && inflight_q && !abort;
    last_xfer = pop && (xfer_left_q == {{MEMWIDTH{1'b0}}, 1'b1});
    occ_plus  = {1'b0, occ_q} + {2'b00, inflight_q};
    // Counting this cycle's pop keeps one read per cycle flowing under ready=1.
    issue     = (state_q == ST_READOUT) && rec_ok && (issue_left_q != '0) &&
                (occ_plus < (pop ? 3'd3 : 3'd2));
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_RECORD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RECORD: begin
        if (rec_ok && freeze_req)
          state_d = (FREEZE_DELAY == 0) ? ST_FROZEN : ST_POST;
      end
      ST_POST: begin
        if (recording && post_q == {{(MEMWIDTH-1){1'b0}}, 1'b1}) state_d = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (rec_ok && unfreeze)                              state_d = ST_RECORD;
        else if (rec_ok && readout_start && count_q != '0)   state_d = ST_READOUT;
      end
      ST_READOUT: begin
        if (abort || last_xfer) state_d = ST_FROZEN;
      end
      default: state_d = ST_RECORD;
    endcase
  end

  always_comb begin
    wen_d        = recording;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    count_d      = count_q;
    post_d       = post_q;
    raddr_d      = raddr_q;
    issue_left_d = issue_left_q;
    xfer_left_d  = xfer_left_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    inflight_d   = issue;
    if (recording) begin
      waddr_d = waddr_q + 1'b1;
      wdata_d = data_in;
      if (!wrapped_w) count_d = count_q + 1'b1;
    end
    if (state_q == ST_RECORD && rec_ok && freeze_req) post_d = FD_W;
    else if (state_q == ST_POST && recording)         post_d = post_q - 1'b1;
    if (state_q == ST_FROZEN && rec_ok) begin
      if (unfreeze) begin
        waddr_d = '1;
        count_d = '0;
      end else if (readout_start && count_q != '0) begin
        raddr_d      = wrapped_w ? waddr_q + 1'b1 : '0;
        issue_left_d = count_q;
        xfer_left_d  = count_q;
      end
    end
    if (state_q == ST_READOUT) begin
      if (issue) begin
        raddr_d      = raddr_q + 1'b1;
        issue_left_d = issue_left_q - 1'b1;
      end
      if (push) begin
        if (wr_ptr_q) buf1_d = spy_read_data;
        else          buf0_d = spy_read_data;
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d    = ~rd_ptr_q;
        xfer_left_d = xfer_left_q - 1'b1;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      if (abort || last_xfer) begin
        occ_d        = 2'd0;
        wr_ptr_d     = 1'b0;
        rd_ptr_d     = 1'b0;
        inflight_d   = 1'b0;
        issue_left_d = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wen_q        <= 1'b0;
      waddr_q      <= '1;
      wdata_q      <= '0;
      count_q      <= '0;
      post_q       <= '0;
      raddr_q      <= '0;
      issue_left_q <= '0;
      xfer_left_q  <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
    end else begin
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      count_q      <= count_d;
      post_q       <= post_d;
      raddr_q      <= raddr_d;
      issue_left_q <= issue_left_d;
      xfer_left_q  <= xfer_left_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
    end
  end

  always_comb begin
    spy_write_enable = wen_q;
    spy_write_addr   = waddr_q;
    spy_write_data   = wdata_q;
    spy_read_enable  = issue;
    spy_read_addr    = raddr_q;
    readout_valid    = (state_q == ST_READOUT) && (occ_q != 2'd0);
    readout_data     = rd_ptr_q ? buf1_q : buf0_q;
    readout_last     = readout_valid && (xfer_left_q == {{MEMWIDTH{1'b0}}, 1'b1});
    frozen           = (state_q == ST_FROZEN) || (state_q == ST_READOUT);
    wrapped          = wrapped_w;
    state_dbg        = state_q;
  end

endmodule
